axi_w_to_stream: RTL and testbench
==================================

Name: axi_w_to_stream

Overview:
- Write-direction counterpart of the read-channel tap.
- Passes AXI4 W-channel beats from the upstream master (AXIS_w* side) to the downstream slave (AXIM_w* side) unchanged.
- Copies every accepted beat into an internal FIFO and presents it on a simple valid/ready stream for the Ethernet packetiser.
- Sits between the interconnect and the memory port, alongside the R-channel tap.

Parameters:
- DATA_WIDTH, 128, W data and stream data width in bits; multiple of 8.
- USER_WIDTH, 64, wuser width.
- FIFO_DEPTH, 16, tap FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  reset, asynchronous assert, active-low.
- ready  in  1  stream consumer ready.
- valid  out  1  stream beat valid.
- in_progress  out  1  a burst is open or tapped beats are still buffered.
- last  out  1  stream beat is the last of its burst.
- data  out  DATA_WIDTH  stream beat, strobe-masked.
- submodule_transaction_length  out  6  beat count of the most recently completed burst, saturating.
- AXIS_wdata  in  DATA_WIDTH  upstream write data.
- AXIS_wstrb  in  DATA_WIDTH/8  upstream byte strobes.
- AXIS_wlast  in  1  upstream last.
- AXIS_wuser  in  USER_WIDTH  upstream user.
- AXIS_wvalid  in  1  upstream valid.
- AXIS_wready  out  1  upstream ready.
- AXIM_wdata  out  DATA_WIDTH  downstream write data.
- AXIM_wstrb  out  DATA_WIDTH/8  downstream strobes.
- AXIM_wlast  out  1  downstream last.
- AXIM_wuser  out  USER_WIDTH  downstream user.
- AXIM_wvalid  out  1  downstream valid.
- AXIM_wready  in  1  downstream ready.

Behaviour:
- Passthrough fields:
  - AXIM_wdata, AXIM_wstrb, AXIM_wlast and AXIM_wuser are combinational copies of the corresponding AXIS_w* inputs.
- Passthrough handshake:
  - AXIM_wvalid = AXIS_wvalid & ~full & resetn.
  - AXIS_wready = AXIM_wready & ~full & resetn.
  - No combinational path from the stream-side ready to AXIS_wready. When full, a simultaneous pop does not unblock the same cycle.
- Accept event: acc = AXIS_wvalid & AXIS_wready. This is identical to the downstream handshake.
- Push on acc: {data masked by strobe, AXIS_wlast}.
  - Masking: byte i = AXIS_wdata byte i if AXIS_wstrb[i], else 8'h00.
- FIFO:
  - Registered storage with read/write pointers, plus a count of width clog2(FIFO_DEPTH)+1.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Stream outputs:
  - valid = ~empty.
  - data and last come from the head entry.
  - A pop occurs on valid & ready.
  - Latency: a beat accepted at edge N is visible on the stream after edge N (1 cycle).
  - Stream order equals W acceptance order.
- Burst tracking:
  - burst_open register: set on acc & ~AXIS_wlast; cleared on acc & AXIS_wlast.
  - in_progress = burst_open | ~empty.
- Beat counter:
  - 6-bit beat_cnt increments on acc, saturating at 63.
  - On acc & AXIS_wlast: submodule_transaction_length <= sat63(beat_cnt + 1), and beat_cnt <= 0.
  - submodule_transaction_length holds its value until the next burst completes.
- State machine: IDLE / BURST, encoded by burst_open.
  - IDLE -> BURST on acc & ~wlast.
  - BURST -> IDLE on acc & wlast.
  - A single-beat burst stays in IDLE.
- Reset (asynchronous, resetn low), including mid-burst:
  - Pointers, count, burst_open, beat_cnt and submodule_transaction_length clear to 0 immediately.
  - valid, last and in_progress are 0; data reads the cleared head, which is 0.
  - AXIS_wready and AXIM_wvalid are 0 while resetn is low.
  - Partial burst contents are discarded. The next burst is counted from 1.
- Error responses are not the tap's concern. B, AW and AR channels are outside this block.

Decomposition:
- Package axi_tap_pkg:
  - typedef tap_entry_t packed struct {last, data}, parameterised via DATA_WIDTH macro or a parameterised struct in the module.
  - function strb_mask(data, strb).
  - localparam LEN_MAX = 6'd63.
- Sub-module tap_fifo:
  - Synchronous single-clock FIFO.
  - Ports: push, push data, pop, head, full, empty.
  - Async active-low reset.
  - The top keeps the handshake gating, burst state and counter.

Test Plan:
- 4-beat burst, ready=1, wstrb all ones, data 1..4:
  - AXIM sees 4 identical beats.
  - Stream emits 1..4, each one cycle after acceptance, with last on beat 4.
  - submodule_transaction_length = 4; in_progress falls after the final pop.
- wdata = all 0xFF, wstrb = 16'h00FF:
  - Stream data upper 64 bits = 0, lower = all FF.
  - AXIM_wdata = all FF.
- ready=0, 20-beat burst, FIFO_DEPTH=16:
  - After 16 accepts, AXIS_wready=0 and AXIM_wvalid=0 with AXIS_wvalid=1.
  - Raise ready: the remaining 4 beats are accepted; the stream emits all 20 in order, last only on beat 20.
- Single-beat burst (wlast=1 on first beat):
  - burst_open never sets; in_progress=1 only while the entry is buffered.
  - Length = 1.
- 70-beat burst, ready=1: length saturates at 63. A following 2-beat burst gives length 2.
- resetn low after 3 beats of an 8-beat burst:
  - valid, in_progress and length go to 0 immediately; AXIS_wready=0.
  - After release, a 5-beat burst yields length 5 and the stream shows only the new 5 beats.

Source files
------------

// File: rtl/axi_tap_pkg.sv
// Shared types and helpers for the AXI channel taps.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package axi_tap_pkg;

  // Saturation ceiling of the 6-bit burst length report.
  localparam logic [5:0] LEN_MAX = 6'd63;

  // Widest data bus the strobe helper handles; callers size in/out with casts.
  localparam int MAX_DATA_WIDTH = 1024;

  // Burst tracking state; the encoding doubles as the burst_open flag.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Zero every byte whose write strobe is low.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_mask(
    input logic [MAX_DATA_WIDTH-1:0]   data,
    input logic [MAX_DATA_WIDTH/8-1:0] strb
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_DATA_WIDTH/8; i++) begin
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    end
    return res;
  endfunction

  // Increment that sticks at LEN_MAX instead of wrapping.
  function automatic logic [5:0] len_inc(input logic [5:0] cnt);
    return (cnt == LEN_MAX) ? LEN_MAX : cnt + 6'd1;
  endfunction

endpackage

// File: rtl/axi_w_to_stream_fifo.sv
// Single-clock tap FIFO holding strobe-masked W beats for the packetiser.
// Latency: an entry pushed at edge N is at the head after edge N.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered-count compares.
module tap_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage; cleared on reset so the head reads zero while the FIFO is empty after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_w_to_stream.sv
// W-channel tap: forwards AXI4 W beats untouched and copies each accepted beat to a stream.
// Latency: passthrough is combinational; a tapped beat appears on the stream one cycle after acceptance.
// Backpressure: a full tap FIFO stalls the W channel; stream ready has no combinational path to AXIS_wready.
module axi_w_to_stream
  import axi_tap_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ready,
  output logic                    valid,
  output logic                    in_progress,
  output logic                    last,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [5:0]              submodule_transaction_length,
  input  logic [DATA_WIDTH-1:0]   AXIS_wdata,
  input  logic [DATA_WIDTH/8-1:0] AXIS_wstrb,
  input  logic                    AXIS_wlast,
  input  logic [USER_WIDTH-1:0]   AXIS_wuser,
  input  logic                    AXIS_wvalid,
  output logic                    AXIS_wready,
  output logic [DATA_WIDTH-1:0]   AXIM_wdata,
  output logic [DATA_WIDTH/8-1:0] AXIM_wstrb,
  output logic                    AXIM_wlast,
  output logic [USER_WIDTH-1:0]   AXIM_wuser,
  output logic                    AXIM_wvalid,
  input  logic                    AXIM_wready
);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } tap_entry_t;

  tap_entry_t   push_entry;
  tap_entry_t   head_entry;
  logic         full;
  logic         empty;
  logic         acc;
  logic         pop;
  burst_state_t state;
  burst_state_t state_next;
  logic [5:0]   beat_cnt;

  assign AXIM_wdata  = AXIS_wdata;
  assign AXIM_wstrb  = AXIS_wstrb;
  assign AXIM_wlast  = AXIS_wlast;
  assign AXIM_wuser  = AXIS_wuser;
  assign AXIM_wvalid = AXIS_wvalid & ~full & resetn;
  assign AXIS_wready = AXIM_wready & ~full & resetn;

  // Upstream acceptance coincides exactly with the downstream handshake.
  assign acc = AXIS_wvalid & AXIS_wready;
  assign pop = valid & ready;

  assign push_entry = '{
    last: AXIS_wlast,
    data: DATA_WIDTH'(strb_mask(MAX_DATA_WIDTH'(AXIS_wdata), (MAX_DATA_WIDTH/8)'(AXIS_wstrb)))
  };

  tap_fifo #(
    .WIDTH ($bits(tap_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (acc),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (full),
    .empty     (empty)
  );

  assign valid       = ~empty;
  assign data        = head_entry.data;
  assign last        = head_entry.last;
  assign in_progress = (state == BURST) | ~empty;

  // Burst state register; reset mid-burst drops back to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Open a burst on a non-last beat, close it on the last; single-beat bursts stay IDLE.
  always_comb begin
    state_next = state;
    if (acc) state_next = AXIS_wlast ? IDLE : BURST;
  end

  // Count beats of the open burst and publish the saturated total when it closes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt                     <= '0;
      submodule_transaction_length <= '0;
    end else if (acc) begin
      if (AXIS_wlast) begin
        submodule_transaction_length <= len_inc(beat_cnt);
        beat_cnt                     <= '0;
      end else begin
        beat_cnt <= len_inc(beat_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axi_w_to_stream.sv
module tb_axi_w_to_stream;
  localparam int DW = 128;
  localparam int UW = 64;
  localparam int SW = DW/8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ready;
  logic          valid;
  logic          in_progress;
  logic          last;
  logic [DW-1:0] data;
  logic [5:0]    len;
  logic [DW-1:0] AXIS_wdata;
  logic [SW-1:0] AXIS_wstrb;
  logic          AXIS_wlast;
  logic [UW-1:0] AXIS_wuser;
  logic          AXIS_wvalid;
  logic          AXIS_wready;
  logic [DW-1:0] AXIM_wdata;
  logic [SW-1:0] AXIM_wstrb;
  logic          AXIM_wlast;
  logic [UW-1:0] AXIM_wuser;
  logic          AXIM_wvalid;
  logic          AXIM_wready;

  int total = 0;
  int bad   = 0;
  logic [DW:0] seen[$];

  always #5 clk = ~clk;

  axi_w_to_stream #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .FIFO_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .ready(ready), .valid(valid),
    .in_progress(in_progress), .last(last), .data(data),
    .submodule_transaction_length(len),
    .AXIS_wdata(AXIS_wdata), .AXIS_wstrb(AXIS_wstrb), .AXIS_wlast(AXIS_wlast),
    .AXIS_wuser(AXIS_wuser), .AXIS_wvalid(AXIS_wvalid), .AXIS_wready(AXIS_wready),
    .AXIM_wdata(AXIM_wdata), .AXIM_wstrb(AXIM_wstrb), .AXIM_wlast(AXIM_wlast),
    .AXIM_wuser(AXIM_wuser), .AXIM_wvalid(AXIM_wvalid), .AXIM_wready(AXIM_wready)
  );

  // Record every stream beat the consumer takes, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn && valid && ready) seen.push_back({last, data});
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded); returns at posedge+1 after acceptance.
  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    bit done;
    done = 1'b0;
    AXIS_wdata  = d;
    AXIS_wstrb  = s;
    AXIS_wlast  = l;
    AXIS_wuser  = d[UW-1:0];
    AXIS_wvalid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      done = AXIS_wready;
      @(posedge clk);
      #1;
    end
    AXIS_wvalid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_beat: beat %h not accepted within 200 cycles", d);
    end
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 100 && valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk(nm, valid, 0);
  endtask

  typedef struct {
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          mready;
    logic          exp_mvalid;
    logic          exp_wready;
    logic          exp_push;
    logic [DW-1:0] exp_sdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{128'h1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 128'h0};
    vecs[1] = '{{16{8'hFF}}, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 128'h0};
    vecs[2] = '{{16{8'hFF}}, 16'h00FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                128'h00000000_00000000_FFFFFFFF_FFFFFFFF};
    vecs[3] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                128'h0123456789ABCDEF_FEDCBA9876543210};
    vecs[4] = '{{16{8'hA5}}, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                128'hA5000000_00000000_00000000_000000A5};
    vecs[5] = '{128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                128'h0};
    vecs[6] = '{{16{8'hFF}}, 16'h0F0F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                128'h00000000_FFFFFFFF_00000000_FFFFFFFF};

    // Reset state, with upstream valid and downstream ready both high.
    resetn      = 1'b1;
    ready       = 1'b0;
    AXIS_wdata  = '0;
    AXIS_wstrb  = '0;
    AXIS_wlast  = 1'b0;
    AXIS_wuser  = '0;
    AXIS_wvalid = 1'b1;
    AXIM_wready = 1'b1;
    #1 resetn = 1'b0;
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_inprog", in_progress, 0);
    chk("rst_len", len, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_wready", AXIS_wready, 0);
    chk("rst_mvalid", AXIM_wvalid, 0);
    AXIS_wvalid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    ready  = 1'b1;

    // Table: passthrough/handshake, then the strobe-masked stream beat one cycle later.
    for (int i = 0; i < 7; i++) begin
      AXIS_wdata  = vecs[i].wdata;
      AXIS_wstrb  = vecs[i].wstrb;
      AXIS_wlast  = 1'b1;
      AXIS_wuser  = vecs[i].wdata[UW-1:0];
      AXIS_wvalid = vecs[i].wvalid;
      AXIM_wready = vecs[i].mready;
      #1;
      chk($sformatf("v%0d_mvalid", i), AXIM_wvalid, vecs[i].exp_mvalid);
      chk($sformatf("v%0d_wready", i), AXIS_wready, vecs[i].exp_wready);
      chk($sformatf("v%0d_mdata", i), AXIM_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_mstrb", i), AXIM_wstrb, vecs[i].wstrb);
      chk($sformatf("v%0d_muser", i), AXIM_wuser, vecs[i].wdata[UW-1:0]);
      chk($sformatf("v%0d_mlast", i), AXIM_wlast, 1);
      @(posedge clk); #1;
      AXIS_wvalid = 1'b0;
      AXIM_wready = 1'b1;
      chk($sformatf("v%0d_svalid", i), valid, vecs[i].exp_push);
      if (vecs[i].exp_push) begin
        chk($sformatf("v%0d_sdata", i), data, vecs[i].exp_sdata);
        chk($sformatf("v%0d_slast", i), last, 1);
      end
      @(posedge clk); #1;
    end
    chk("tbl_len", len, 1);
    chk("tbl_inprog", in_progress, 0);

    // 4-beat burst, consumer always ready.
    seen.delete();
    for (int k = 1; k <= 4; k++) begin
      send_beat(DW'(k), 16'hFFFF, k == 4);
      chk($sformatf("a%0d_valid", k), valid, 1);
      chk($sformatf("a%0d_data", k), data, DW'(k));
      chk($sformatf("a%0d_last", k), last, (k == 4) ? 1 : 0);
      chk($sformatf("a%0d_inprog", k), in_progress, 1);
      if (k == 3) chk("a_len_hold", len, 1);
    end
    chk("a_len", len, 4);
    @(posedge clk); #1;
    chk("a_valid_end", valid, 0);
    chk("a_inprog_end", in_progress, 0);

    // 20-beat burst into a stalled consumer: fills at 16, then drains in order.
    seen.delete();
    ready = 1'b0;
    for (int k = 1; k <= 16; k++) send_beat(DW'(k), 16'hFFFF, 1'b0);
    AXIS_wdata  = DW'(17);
    AXIS_wvalid = 1'b1;
    #1;
    chk("b_full_wready", AXIS_wready, 0);
    chk("b_full_mvalid", AXIM_wvalid, 0);
    chk("b_full_valid", valid, 1);
    ready = 1'b1;
    #1;
    chk("b_nocomb_wready", AXIS_wready, 0);
    for (int k = 17; k <= 20; k++) send_beat(DW'(k), 16'hFFFF, k == 20);
    wait_drain("b_drain");
    chk("b_count", DW'(seen.size()), 20);
    for (int i = 0; i < 20 && i < seen.size(); i++) begin
      chk($sformatf("b%0d_data", i + 1), seen[i][DW-1:0], DW'(i + 1));
      chk($sformatf("b%0d_last", i + 1), seen[i][DW], (i == 19) ? 1 : 0);
    end
    chk("b_len", len, 20);
    chk("b_inprog", in_progress, 0);

    // Single-beat burst held in the FIFO, then released.
    ready = 1'b0;
    send_beat(128'hC, 16'hFFFF, 1'b1);
    chk("c_len", len, 1);
    chk("c_inprog_buf", in_progress, 1);
    @(posedge clk); #1;
    chk("c_inprog_hold", in_progress, 1);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("c_valid_end", valid, 0);
    chk("c_inprog_end", in_progress, 0);

    // 70-beat burst saturates the length; a following 2-beat burst reports 2.
    for (int k = 1; k <= 70; k++) begin
      send_beat(DW'(k), 16'hFFFF, k == 70);
      if (k == 69) chk("d_len_hold", len, 1);
    end
    chk("d_len_sat", len, 63);
    wait_drain("d_drain");
    send_beat(128'h1, 16'hFFFF, 1'b0);
    send_beat(128'h2, 16'hFFFF, 1'b1);
    chk("d_len2", len, 2);
    wait_drain("d_drain2");

    // Reset after 3 beats of an 8-beat burst; partial burst is discarded.
    ready = 1'b0;
    seen.delete();
    for (int k = 1; k <= 3; k++) send_beat(DW'(k), 16'hFFFF, 1'b0);
    chk("e_len_pre", len, 2);
    chk("e_inprog_pre", in_progress, 1);
    AXIS_wdata  = DW'(4);
    AXIS_wvalid = 1'b1;
    resetn      = 1'b0;
    #1;
    chk("e_valid", valid, 0);
    chk("e_inprog", in_progress, 0);
    chk("e_len", len, 0);
    chk("e_wready", AXIS_wready, 0);
    chk("e_mvalid", AXIM_wvalid, 0);
    chk("e_data", data, 0);
    @(posedge clk); @(posedge clk); #1;
    chk("e_valid_held", valid, 0);
    AXIS_wvalid = 1'b0;
    resetn      = 1'b1;
    ready       = 1'b1;
    for (int k = 1; k <= 5; k++) send_beat(DW'(32'h100 + k), 16'hFFFF, k == 5);
    chk("e_len_new", len, 5);
    wait_drain("e_drain");
    chk("e_count", DW'(seen.size()), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      chk($sformatf("e%0d_data", i + 1), seen[i][DW-1:0], DW'(32'h101 + i));
      chk($sformatf("e%0d_last", i + 1), seen[i][DW], (i == 4) ? 1 : 0);
    end
    chk("e_inprog_end", in_progress, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
